// File: rtl/seg_pkg.sv
// Shared types, glyph constants and helpers for the seven-segment display controller.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // Active-high glyphs, bit order g..a
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Decimal digits needed for a w-bit unsigned value: floor(w*log10(2))+1
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (w * 30103) / 100000 + 1;
  endfunction

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  // Full segment byte with dp off, in the pin polarity of the board
  function automatic logic [7:0] seg_polarity(input logic [6:0] glyph, input bit active_low);
    return active_low ? ~{1'b0, glyph} : {1'b0, glyph};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle after start, done flags the last shift.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BCD_W = 4 * bcd_digits(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mag,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int unsigned BCD_DIGITS = bcd_digits(DATA_W);
  localparam int unsigned CNT_W      = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  // done is high during the cycle that performs the final shift
  always_comb begin
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    if (start) begin
      mag_d = mag;
      bcd_d = '0;
      cnt_d = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
        if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      {bcd_d, mag_d} = {adj, mag_q} << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
    done_d = (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: signed/unsigned BCD conversion with a one-entry
// pending buffer, leading-zero blanking, overflow dashes and multiplexed digit refresh.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  value_valid,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS:0]   digit_sel,
  output logic [7:0]            segment
);

  localparam int unsigned BCD_DIGITS  = bcd_digits(DATA_W);
  localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
  localparam int unsigned DISP_W      = 4 * NUM_DIGITS;
  localparam int unsigned SHOW_DIGITS = (NUM_DIGITS < BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
  localparam int unsigned DSEL_W      = NUM_DIGITS + 1;
  localparam int unsigned SCAN_W      = $clog2(NUM_DIGITS + 1);
  localparam int unsigned PRE_W       = $clog2(REFRESH_DIV);
  localparam logic [7:0]  SEG_OFF     = seg_polarity(GLYPH_BLANK, SEG_ACTIVE_LOW);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   cap_val_q, cap_val_d;
  logic                cap_signed_q, cap_signed_d;
  logic [DATA_W-1:0]   pend_val_q, pend_val_d;
  logic                pend_signed_q, pend_signed_d;
  logic                pend_valid_q, pend_valid_d;
  logic                neg_work_q, neg_work_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                disp_neg_q, disp_neg_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [DSEL_W-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;

  logic                neg_c;
  logic [DATA_W-1:0]   mag_c;
  logic                start_c;
  logic                eng_done;
  logic [BCD_W-1:0]    eng_bcd;
  logic                upper_zero;
  logic [3:0]          nib;
  logic [6:0]          glyph;

  assign neg_c   = cap_signed_q & cap_val_q[DATA_W-1];
  assign mag_c   = neg_c ? (~cap_val_q + DATA_W'(1)) : cap_val_q;
  assign start_c = (state_q == ST_LOAD);

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_c),
    .mag     (mag_c),
    .done    (eng_done),
    .bcd     (eng_bcd)
  );

  always_comb begin
    state_d       = state_q;
    cap_val_d     = cap_val_q;
    cap_signed_d  = cap_signed_q;
    pend_val_d    = pend_val_q;
    pend_signed_d = pend_signed_q;
    pend_valid_d  = pend_valid_q;
    neg_work_d    = neg_work_q;
    disp_d        = disp_q;
    disp_neg_d    = disp_neg_q;
    ovf_d         = ovf_q;

    // Strobes arriving mid-conversion park in pending; newest wins
    if (value_valid && (state_q == ST_LOAD || state_q == ST_SHIFT)) begin
      pend_val_d    = value_in;
      pend_signed_d = signed_mode;
      pend_valid_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          cap_val_d    = value_in;
          cap_signed_d = signed_mode;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        neg_work_d = neg_c;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (eng_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d     = '0;
        for (int i = 0; i < int'(SHOW_DIGITS); i++) disp_d[4*i +: 4] = eng_bcd[4*i +: 4];
        disp_neg_d = neg_work_q;
        ovf_d      = 1'b0;
        for (int i = int'(NUM_DIGITS); i < int'(BCD_DIGITS); i++) begin
          if (eng_bcd[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        end
        // A strobe in this cycle is newer than anything pending and goes straight to capture
        if (value_valid) begin
          cap_val_d    = value_in;
          cap_signed_d = signed_mode;
          pend_valid_d = 1'b0;
          state_d      = ST_LOAD;
        end else if (pend_valid_q) begin
          cap_val_d    = pend_val_q;
          cap_signed_d = pend_signed_q;
          pend_valid_d = 1'b0;
          state_d      = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // Refresh scan and rendering of the digit that will be selected next cycle
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    scan_d  = scan_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      scan_d  = (scan_q == SCAN_W'(NUM_DIGITS)) ? '0 : scan_q + SCAN_W'(1);
    end
    sel_d      = DSEL_W'(1) << scan_d;
    upper_zero = ((disp_q >> (4 * 32'(scan_d))) == '0);
    nib        = 4'(disp_q >> (4 * 32'(scan_d)));
    if (scan_d == SCAN_W'(NUM_DIGITS)) glyph = disp_neg_q ? GLYPH_DASH : GLYPH_BLANK;
    else if (ovf_q)                    glyph = GLYPH_DASH;
    else if (scan_d != '0 && upper_zero) glyph = GLYPH_BLANK;
    else                               glyph = digit_glyph(nib);
    seg_d = seg_polarity(glyph, SEG_ACTIVE_LOW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cap_val_q     <= '0;
      cap_signed_q  <= 1'b0;
      pend_val_q    <= '0;
      pend_signed_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      neg_work_q    <= 1'b0;
      disp_q        <= '0;
      disp_neg_q    <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      presc_q       <= '0;
      scan_q        <= '0;
      sel_q         <= DSEL_W'(1);
      seg_q         <= SEG_OFF;
    end else begin
      state_q       <= state_d;
      cap_val_q     <= cap_val_d;
      cap_signed_q  <= cap_signed_d;
      pend_val_q    <= pend_val_d;
      pend_signed_q <= pend_signed_d;
      pend_valid_q  <= pend_valid_d;
      neg_work_q    <= neg_work_d;
      disp_q        <= disp_d;
      disp_neg_q    <= disp_neg_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
      presc_q       <= presc_d;
      scan_q        <= scan_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
    end
  end

  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign digit_sel = sel_q;
  assign segment   = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl (32-bit, 4 digits, 4-cycle dwell, active-low segments).
module tb_seg_display_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] value_in;
  logic        value_valid;
  logic        signed_mode;
  logic        busy;
  logic        overflow;
  logic [4:0]  digit_sel;
  logic [7:0]  segment;

  int checks = 0;
  int errors = 0;

  seg_display_ctrl #(
    .DATA_W(32), .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .signed_mode (signed_mode),
    .busy        (busy),
    .overflow    (overflow),
    .digit_sel   (digit_sel),
    .segment     (segment)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] tb_glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  function automatic longint unsigned model_mag(input logic [31:0] v, input logic s);
    if (s && v[31]) return 64'h1_0000_0000 - 64'(v);
    return 64'(v);
  endfunction

  function automatic logic model_ovf(input logic [31:0] v, input logic s);
    return model_mag(v, s) > 64'd9999;
  endfunction

  // Expected active-low segment byte for each scan position (index 4 = sign)
  function automatic logic [4:0][7:0] model_segs(input logic [31:0] v, input logic s);
    logic [4:0][7:0] r;
    longint unsigned mag, p;
    logic [6:0] g;
    mag = model_mag(v, s);
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (mag > 64'd9999)             g = 7'h40;
      else if (i > 0 && mag / p == 0) g = 7'h00;
      else                            g = tb_glyph(int'((mag / p) % 10));
      r[i] = ~{1'b0, g};
      p = p * 10;
    end
    r[4] = (s && v[31]) ? ~{1'b0, 7'h40} : 8'hFF;
    return r;
  endfunction

  // Strobe v, then count busy cycles; optional injected strobes and a mid-run units check
  task automatic conv(input logic [31:0] v, input logic s,
                      input int inj1, input logic [31:0] iv1,
                      input int inj2, input logic [31:0] iv2,
                      input int win_lo, input int win_hi, input logic [7:0] win_seg,
                      output int n);
    value_in = v; signed_mode = s; value_valid = 1'b1;
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      value_valid = 1'b0;
      if (!busy) break;
      n++;
      if (k >= win_lo && k <= win_hi && digit_sel == 5'b00001)
        check("mid_units", segment, win_seg);
      if (k == inj1) begin value_in = iv1; signed_mode = 1'b0; value_valid = 1'b1; end
      if (k == inj2) begin value_in = iv2; signed_mode = 1'b0; value_valid = 1'b1; end
    end
  endtask

  // Watch two frames: one-hot select, per-digit segments, 4-cycle dwell
  task automatic check_frame(input string tag, input logic [4:0][7:0] exp_segs);
    logic [4:0] prev;
    int run;
    bit seen;
    prev = digit_sel; run = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check({tag, "_onehot"}, 64'($onehot(digit_sel)), 64'd1);
      for (int i = 0; i < 5; i++)
        if (digit_sel[i]) check($sformatf("%s_seg%0d", tag, i), segment, exp_segs[i]);
      if (digit_sel != prev) begin
        if (seen) check({tag, "_dwell"}, 64'(run), 64'd4);
        seen = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = digit_sel;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] v, input logic s);
    int n;
    conv(v, s, -1, 0, -1, 0, -1, -1, 8'h00, n);
    check({tag, "_busy_len"}, 64'(n), 64'd34);
    check({tag, "_ovf"}, 64'(overflow), 64'(model_ovf(v, s)));
    check_frame(tag, model_segs(v, s));
  endtask

  initial begin
    int n;
    logic [31:0] rv;
    logic        rs;
    reset_n = 1'b0; value_in = '0; value_valid = 1'b0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_sel", 64'(digit_sel), 64'd1);
    check("rst_seg", 64'(segment), 64'hFF);
    reset_n = 1'b1;
    @(negedge clk);

    run_case("u1234", 32'd1234, 1'b0);
    run_case("neg7", 32'hFFFF_FFF9, 1'b1);
    run_case("big_u", 32'hFFFF_FFF9, 1'b0);
    run_case("zero", 32'd0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 3))
        0:       rv = $urandom;
        1:       rv = 32'($urandom_range(0, 9999));
        2:       rv = -32'($urandom_range(1, 9999));
        default: rv = 32'($urandom_range(0, 99999));
      endcase
      rs = 1'($urandom_range(0, 1));
      run_case($sformatf("rnd%0d", t), rv, rs);
    end

    // 5 converts; 6 then 7 arrive mid-conversion, only 7 follows
    conv(32'd5, 1'b0, 5, 32'd6, 10, 32'd7, 36, 68, model_segs(32'd5, 1'b0)[0], n);
    check("pend_busy_len", 64'(n), 64'd68);
    check("pend_ovf", 64'(overflow), 64'd0);
    check_frame("pend7", model_segs(32'd7, 1'b0));

    // Strobe in the COMMIT cycle chains without an idle gap
    conv(32'd42, 1'b0, 34, 32'hFFFF_FEC3, -1, 0, 36, 68, model_segs(32'd42, 1'b0)[0], n);
    check("commit_busy_len", 64'(n), 64'd68);
    check_frame("commit_next", model_segs(32'hFFFF_FEC3, 1'b0));

    run_case("minint", 32'h8000_0000, 1'b1);

    // Reset mid-SHIFT clears everything without waiting for a clock
    value_in = 32'd12; signed_mode = 1'b0; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    check("arst_sel", 64'(digit_sel), 64'd1);
    check("arst_seg", 64'(segment), 64'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    check_frame("arst_disp", model_segs(32'd0, 1'b0));
    check("arst_idle", 64'(busy), 64'd0);
    run_case("after_rst", 32'd905, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
